// File: rtl/mux8_rr_arbiter_if.sv
// Bus between eight requester slices, the round-robin arbiter and one valid/ready consumer.
// Build option ARB_LOCK_EN adds the lock signal.
interface mux8_rr_arbiter_if #(
    parameter int DW    = 1,
    parameter int CNT_W = 8
);
    logic [7:0]      req;
    logic [8*DW-1:0] din;
    logic            out_ready;
`ifdef ARB_LOCK_EN
    logic            lock;
`endif
    logic [7:0]      grant;
    logic [2:0]      sel;
    logic [DW-1:0]   dout;
    logic            out_valid;
    logic            busy;
    logic [CNT_W-1:0] beat_cnt;

`ifdef ARB_LOCK_EN
    modport master (input req, din, out_ready, lock,
                    output grant, sel, dout, out_valid, busy, beat_cnt);
    modport slave  (output req, din, out_ready, lock,
                    input grant, sel, dout, out_valid, busy, beat_cnt);
`else
    modport master (input req, din, out_ready,
                    output grant, sel, dout, out_valid, busy, beat_cnt);
    modport slave  (output req, din, out_ready,
                    input grant, sel, dout, out_valid, busy, beat_cnt);
`endif
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter metering each grant of a shared 8:1 mux to HOLD_BEATS beats.
// Build option ARB_LOCK_EN adds a lock input that suppresses the beat limit.
module mux8_rr_arbiter #(
    parameter int DW         = 1,
    parameter int HOLD_BEATS = 4,
    parameter int CNT_W      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    mux8_rr_arbiter_if.master  bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_BEATS - 1);

    state_t           state, state_n;
    logic [7:0]       grant_q, grant_n;
    logic [2:0]       sel_q, sel_n;
    logic [2:0]       ptr_q, ptr_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;

    logic [2:0] base;
    logic [2:0] win;
    logic       win_ok;
    logic       busy;
    logic       req_g;
    logic       beat;
    logic       at_limit;
    logic       release_g;

    // When a grant releases, the outgoing index becomes the new pointer, so
    // the scan always starts just after the current (or last) granted index.
    always_comb begin
        base   = (state == BUSY) ? sel_q : ptr_q;
        win    = base;
        win_ok = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (!win_ok && bus.req[base + 3'(k)]) begin
                win    = base + 3'(k);
                win_ok = 1'b1;
            end
        end
    end

    always_comb begin
        busy     = (state == BUSY);
        req_g    = bus.req[sel_q];
        beat     = busy & req_g & bus.out_ready;
        at_limit = (cnt_q >= LAST);
`ifdef ARB_LOCK_EN
        release_g = (busy & ~req_g) | (beat & at_limit & ~bus.lock);
`else
        release_g = (busy & ~req_g) | (beat & at_limit);
`endif
    end

    always_comb begin
        state_n = state;
        grant_n = grant_q;
        sel_n   = sel_q;
        ptr_n   = ptr_q;
        cnt_n   = cnt_q;
        case (state)
            IDLE: begin
                if (win_ok) begin
                    state_n = BUSY;
                    grant_n = 8'b0000_0001 << win;
                    sel_n   = win;
                    cnt_n   = '0;
                end
            end
            BUSY: begin
                if (release_g) begin
                    ptr_n = sel_q;
                    cnt_n = '0;
                    if (win_ok) begin
                        grant_n = 8'b0000_0001 << win;
                        sel_n   = win;
                    end else begin
                        state_n = IDLE;
                        grant_n = '0;
                    end
                end else if (beat) begin
`ifdef ARB_LOCK_EN
                    // Locked bursts can run past HOLD_BEATS, so hold at the top value.
                    if (cnt_q != '1) begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
`else
                    cnt_n = cnt_q + CNT_W'(1);
`endif
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            ptr_q   <= 3'd7;
            cnt_q   <= '0;
        end else begin
            state   <= state_n;
            grant_q <= grant_n;
            sel_q   <= sel_n;
            ptr_q   <= ptr_n;
            cnt_q   <= cnt_n;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.sel       = sel_q;
    assign bus.busy      = busy;
    assign bus.beat_cnt  = cnt_q;
    assign bus.out_valid = busy & req_g;
    assign bus.dout      = bus.din[sel_q*DW +: DW];
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter: one DUT with HOLD_BEATS=4, one with HOLD_BEATS=1.
// Build with ARB_LOCK_EN defined to add the lock sequence.
module tb_mux8_rr_arbiter;
    logic clk;
    logic rst_n;

    int total = 0;
    int bad   = 0;

    logic [7:0] cur_req;
    logic [7:0] din_v;

    typedef struct {
        string      tag;
        int         which;
        logic [7:0] grant;
        logic [2:0] sel;
        logic       busy;
        logic [7:0] cnt;
    } exp_t;

    exp_t sbq[$];

    mux8_rr_arbiter_if #(.DW(1), .CNT_W(8)) bus4 ();
    mux8_rr_arbiter_if #(.DW(1), .CNT_W(8)) bus1 ();

    mux8_rr_arbiter #(.DW(1), .HOLD_BEATS(4), .CNT_W(8)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    mux8_rr_arbiter #(.DW(1), .HOLD_BEATS(1), .CNT_W(8)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare the DUT selected by the oldest scoreboard entry against it.
    task automatic checkOutput();
        exp_t       e;
        logic [7:0] g;
        logic [2:0] s;
        logic       b;
        logic [7:0] c;
        logic       v;
        logic       d;
        logic       ev;
        logic       ed;
        e = sbq.pop_front();
        if (e.which == 1) begin
            g = bus1.grant; s = bus1.sel; b = bus1.busy;
            c = bus1.beat_cnt; v = bus1.out_valid; d = bus1.dout[0];
        end else begin
            g = bus4.grant; s = bus4.sel; b = bus4.busy;
            c = bus4.beat_cnt; v = bus4.out_valid; d = bus4.dout[0];
        end
        ev = e.busy & cur_req[e.sel];
        ed = din_v[e.sel];
        total++;
        assert (g === e.grant) else begin
            bad++; $error("[TB] FAIL %s grant: got %h want %h", e.tag, g, e.grant);
        end
        total++;
        assert (s === e.sel) else begin
            bad++; $error("[TB] FAIL %s sel: got %0d want %0d", e.tag, s, e.sel);
        end
        total++;
        assert (b === e.busy) else begin
            bad++; $error("[TB] FAIL %s busy: got %b want %b", e.tag, b, e.busy);
        end
        total++;
        assert (c === e.cnt) else begin
            bad++; $error("[TB] FAIL %s beat_cnt: got %0d want %0d", e.tag, c, e.cnt);
        end
        total++;
        assert (v === ev) else begin
            bad++; $error("[TB] FAIL %s out_valid: got %b want %b", e.tag, v, ev);
        end
        total++;
        assert (d === ed) else begin
            bad++; $error("[TB] FAIL %s dout: got %b want %b", e.tag, d, ed);
        end
    endtask

    // Drive one cycle of inputs, queue the state expected after the next edge, then check.
    task automatic applyStimulus(input string tag, input int which, input logic rn,
                                 input logic [7:0] r, input logic rdy, input logic lk,
                                 input logic [7:0] eg, input logic [2:0] es,
                                 input logic eb, input logic [7:0] ec);
        exp_t e;
        @(negedge clk);
        rst_n          = rn;
        cur_req        = r;
        bus4.req       = r;
        bus1.req       = r;
        bus4.out_ready = rdy;
        bus1.out_ready = rdy;
`ifdef ARB_LOCK_EN
        bus4.lock      = lk;
        bus1.lock      = lk;
`endif
        e.tag = tag; e.which = which; e.grant = eg; e.sel = es; e.busy = eb; e.cnt = ec;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        din_v          = 8'hAA;
        rst_n          = 1'b0;
        cur_req        = 8'h00;
        bus4.req       = 8'h00;
        bus1.req       = 8'h00;
        bus4.din       = din_v;
        bus1.din       = din_v;
        bus4.out_ready = 1'b0;
        bus1.out_ready = 1'b0;
`ifdef ARB_LOCK_EN
        bus4.lock      = 1'b0;
        bus1.lock      = 1'b0;
`endif

        applyStimulus("reset0",     0, 0, 8'h00, 0, 0, 8'h00, 3'd0, 0, 0);
        applyStimulus("reset1",     0, 0, 8'h00, 0, 0, 8'h00, 3'd0, 0, 0);
        applyStimulus("reset_h1",   1, 0, 8'h00, 0, 0, 8'h00, 3'd0, 0, 0);
        applyStimulus("idle",       0, 1, 8'h00, 0, 0, 8'h00, 3'd0, 0, 0);

        applyStimulus("single_gnt", 0, 1, 8'h08, 1, 0, 8'h08, 3'd3, 1, 0);
        applyStimulus("single_b1",  0, 1, 8'h08, 1, 0, 8'h08, 3'd3, 1, 1);
        applyStimulus("single_b2",  0, 1, 8'h08, 1, 0, 8'h08, 3'd3, 1, 2);
        applyStimulus("single_b3",  0, 1, 8'h08, 1, 0, 8'h08, 3'd3, 1, 3);
        applyStimulus("single_re",  0, 1, 8'h08, 1, 0, 8'h08, 3'd3, 1, 0);
        applyStimulus("to_idle",    0, 1, 8'h00, 1, 0, 8'h00, 3'd3, 0, 0);

        applyStimulus("bp_gnt",     0, 1, 8'h05, 1, 0, 8'h01, 3'd0, 1, 0);
        applyStimulus("bp_r1",      0, 1, 8'h05, 1, 0, 8'h01, 3'd0, 1, 1);
        applyStimulus("bp_s1",      0, 1, 8'h05, 0, 0, 8'h01, 3'd0, 1, 1);
        applyStimulus("bp_s2",      0, 1, 8'h05, 0, 0, 8'h01, 3'd0, 1, 1);
        applyStimulus("bp_r2",      0, 1, 8'h05, 1, 0, 8'h01, 3'd0, 1, 2);
        applyStimulus("bp_r3",      0, 1, 8'h05, 1, 0, 8'h01, 3'd0, 1, 3);
        applyStimulus("bp_move",    0, 1, 8'h05, 1, 0, 8'h04, 3'd2, 1, 0);

        applyStimulus("drop_b1",    0, 1, 8'h25, 1, 0, 8'h04, 3'd2, 1, 1);
        applyStimulus("drop_mv",    0, 1, 8'h21, 1, 0, 8'h20, 3'd5, 1, 0);
        applyStimulus("drop_b2",    0, 1, 8'h21, 1, 0, 8'h20, 3'd5, 1, 1);
        applyStimulus("mid_rst",    0, 0, 8'h21, 1, 0, 8'h00, 3'd0, 0, 0);
        applyStimulus("post_rst",   0, 1, 8'h21, 0, 0, 8'h01, 3'd0, 1, 0);
        applyStimulus("stall",      0, 1, 8'h21, 0, 0, 8'h01, 3'd0, 1, 0);
        applyStimulus("idle2",      0, 1, 8'h00, 0, 0, 8'h00, 3'd0, 0, 0);

        applyStimulus("rr_reset",   1, 0, 8'h00, 0, 0, 8'h00, 3'd0, 0, 0);
        for (int k = 0; k < 9; k++) begin
            applyStimulus($sformatf("rr%0d", k), 1, 1, 8'hFF, 1, 0,
                          8'(8'h01 << (k % 8)), 3'(k % 8), 1, 0);
        end

`ifdef ARB_LOCK_EN
        applyStimulus("lk_reset",   0, 0, 8'h03, 1, 1, 8'h00, 3'd0, 0, 0);
        applyStimulus("lk_gnt",     0, 1, 8'h03, 1, 1, 8'h01, 3'd0, 1, 0);
        for (int k = 1; k <= 6; k++) begin
            applyStimulus($sformatf("lk_b%0d", k), 0, 1, 8'h03, 1, 1,
                          8'h01, 3'd0, 1, 8'(k));
        end
        applyStimulus("lk_release", 0, 1, 8'h02, 1, 1, 8'h02, 3'd1, 1, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
